// File: rtl/axil_axi_adapter.sv
// rtl/axil_axi_adapter.sv - AXI4-Lite slave to AXI4 master bridge, single-beat bursts, one outstanding per path.
// Optional AXIL_AXI_ADAPTER_RESP_CHECK_EN: flags ID / RLAST mismatches as SLVERR.
module axil_axi_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH = 8,
    parameter int AXI_ID = 0,
    parameter logic [3:0] AXI_CACHE = 4'b0011
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(AXI_ID);

    typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_WAIT_B, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT_R, RD_RESP} rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                  aw_held, w_held, aw_done, w_done;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [2:0]            awprot_q, arprot_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [1:0]            bresp_in, rresp_in;

`ifdef AXIL_AXI_ADAPTER_RESP_CHECK_EN
    assign bresp_in = (m_axi_bid != ID_VAL) ? 2'b10 : m_axi_bresp;
    assign rresp_in = ((m_axi_rid != ID_VAL) || !m_axi_rlast) ? 2'b10 : m_axi_rresp;
`else
    logic unused_resp_fields;
    assign unused_resp_fields = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
    assign bresp_in = m_axi_bresp;
    assign rresp_in = m_axi_rresp;
`endif

    // Burst shape is fixed: every transaction is one full-width INCR beat.
    assign m_axi_awid    = ID_VAL;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE;
    assign m_axi_awprot  = awprot_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = ID_VAL;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE;
    assign m_axi_arprot  = arprot_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        wr_state_next  = wr_state;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        m_axi_awvalid  = 1'b0;
        m_axi_wvalid   = 1'b0;
        m_axi_bready   = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s_axil_awready = !aw_held;
                s_axil_wready  = !w_held;
                if ((aw_held || s_axil_awvalid) && (w_held || s_axil_wvalid))
                    wr_state_next = WR_ISSUE;
            end
            WR_ISSUE: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
                    wr_state_next = WR_WAIT_B;
            end
            WR_WAIT_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid)
                    wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready)
                    wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next  = rd_state;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        m_axi_arvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                s_axil_arready = 1'b1;
                if (s_axil_arvalid)
                    rd_state_next = RD_ISSUE;
            end
            RD_ISSUE: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready)
                    rd_state_next = RD_WAIT_R;
            end
            RD_WAIT_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid)
                    rd_state_next = RD_RESP;
            end
            RD_RESP: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready)
                    rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // AW and W may land in different cycles; each is latched once and held until the response retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= '0;
            awprot_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (s_axil_awvalid && !aw_held) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= s_axil_awaddr;
                        awprot_q <= s_axil_awprot;
                    end
                    if (s_axil_wvalid && !w_held) begin
                        w_held  <= 1'b1;
                        wdata_q <= s_axil_wdata;
                        wstrb_q <= s_axil_wstrb;
                    end
                end
                WR_ISSUE: begin
                    if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
                end
                WR_WAIT_B: begin
                    if (m_axi_bvalid) bresp_q <= bresp_in;
                end
                WR_RESP: begin
                    if (s_axil_bready) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q <= '0;
            arprot_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            if (rd_state == RD_IDLE && s_axil_arvalid) begin
                araddr_q <= s_axil_araddr;
                arprot_q <= s_axil_arprot;
            end
            if (rd_state == RD_WAIT_R && m_axi_rvalid) begin
                rdata_q <= m_axi_rdata;
                rresp_q <= rresp_in;
            end
        end
    end

endmodule

// File: tb/tb_axil_axi_adapter.sv
// tb/tb_axil_axi_adapter.sv - directed self-checking bench for axil_axi_adapter.
module tb_axil_axi_adapter;

    logic        clk, rst;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic [2:0]  s_axil_awprot, s_axil_arprot;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;
    logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axil_axi_adapter dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model: AW/W always ready, AR ready after ar_delay waiting cycles, one response per burst.
    logic        b_hold;
    int          ar_delay, ar_wait;
    logic        got_aw, got_w;
    int          aw_hs_cnt = 0, w_hs_cnt = 0;
    logic [7:0]  s_bid, s_rid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        s_rlast;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [25:0] cap_aw_fields, cap_ar_fields;
    logic [2:0]  cap_awprot, cap_arprot;
    logic [3:0]  cap_wstrb;
    logic        cap_wlast;
    logic        aw_hs, w_hs;

    assign m_axi_awready = 1'b1;
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = (ar_wait >= ar_delay);
    assign m_axi_bid     = s_bid;
    assign m_axi_bresp   = s_bresp;
    assign m_axi_rid     = s_rid;
    assign m_axi_rdata   = s_rdata;
    assign m_axi_rresp   = s_rresp;
    assign m_axi_rlast   = s_rlast;
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            got_aw <= 1'b0;
            got_w <= 1'b0;
            m_axi_bvalid <= 1'b0;
            m_axi_rvalid <= 1'b0;
            ar_wait <= 0;
        end else begin
            if (aw_hs) begin
                got_aw <= 1'b1;
                aw_hs_cnt <= aw_hs_cnt + 1;
                cap_awaddr <= m_axi_awaddr;
                cap_awprot <= m_axi_awprot;
                cap_aw_fields <= {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awid};
            end
            if (w_hs) begin
                got_w <= 1'b1;
                w_hs_cnt <= w_hs_cnt + 1;
                cap_wdata <= m_axi_wdata;
                cap_wstrb <= m_axi_wstrb;
                cap_wlast <= m_axi_wlast;
            end
            if (m_axi_bvalid && m_axi_bready)
                m_axi_bvalid <= 1'b0;
            else if (!m_axi_bvalid && !b_hold && (got_aw || aw_hs) && (got_w || w_hs)) begin
                m_axi_bvalid <= 1'b1;
                got_aw <= 1'b0;
                got_w <= 1'b0;
            end
            if (m_axi_rvalid && m_axi_rready)
                m_axi_rvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_wait <= 0;
                m_axi_rvalid <= 1'b1;
                cap_araddr <= m_axi_araddr;
                cap_arprot <= m_axi_arprot;
                cap_ar_fields <= {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arid};
            end else if (m_axi_arvalid) begin
                ar_wait <= ar_wait + 1;
            end
        end
    end

    localparam logic [25:0] EXP_FIELDS = {8'd0, 3'd2, 2'd1, 1'b0, 4'b0011, 8'd0};

    // All tasks start and end on a falling edge.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        int  t;
        logic aw_acc, w_acc;
        s_axil_awaddr = a; s_axil_awprot = p; s_axil_awvalid = 1'b1;
        s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
        t = 0;
        while ((s_axil_awvalid || s_axil_wvalid) && t < 50) begin
            aw_acc = s_axil_awvalid && s_axil_awready;
            w_acc  = s_axil_wvalid && s_axil_wready;
            @(negedge clk);
            t++;
            if (aw_acc) s_axil_awvalid = 1'b0;
            if (w_acc) s_axil_wvalid = 1'b0;
        end
        if (t >= 50) chk("aw_w_accept_timeout", 64'(t), 64'(0));
    endtask

    task automatic wait_bvalid(output int lat);
        lat = 1;
        while (!s_axil_bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_rvalid(output int lat);
        lat = 1;
        while (!s_axil_rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_b(output logic [1:0] resp);
        resp = s_axil_bresp;
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
    endtask

    task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
        data = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    int          lat, base_aw, base_w;
    logic        stable;
    logic [1:0]  resp;
    logic [31:0] data;

    initial begin
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        b_hold = 1'b0; ar_delay = 0;
        s_bid = 8'd0; s_bresp = 2'b00; s_rid = 8'd0; s_rresp = 2'b00; s_rdata = '0; s_rlast = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
        chk("rst_valids", 64'({s_axil_bvalid, s_axil_rvalid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
        chk("rst_mready", 64'({m_axi_bready, m_axi_rready}), 64'(0));
        chk("rst_payload", {m_axi_awaddr, m_axi_wdata}, 64'(0));
        chk("rst_resp", 64'({s_axil_rdata, s_axil_bresp, s_axil_rresp, m_axi_awprot, m_axi_arprot, m_axi_araddr}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single write, zero-wait slave
        send_aw_w(32'h1000, 32'hDEADBEEF, 4'hF, 3'b010);
        chk("t1_awready_busy", 64'({s_axil_awready, s_axil_wready}), 64'(0));
        chk("t1_m_valids", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(2'b11));
        wait_bvalid(lat);
        chk("t1_b_latency", 64'(lat), 64'(3));
        chk("t1_aw_fields", 64'(cap_aw_fields), 64'(EXP_FIELDS));
        chk("t1_aw_addr_prot", 64'({cap_awaddr, cap_awprot}), 64'({32'h1000, 3'b010}));
        chk("t1_w_beat", 64'({cap_wdata, cap_wstrb, cap_wlast}), 64'({32'hDEADBEEF, 4'hF, 1'b1}));
        take_b(resp);
        chk("t1_bresp", 64'(resp), 64'(0));
        chk("t1_idle_ready", 64'({s_axil_awready, s_axil_wready, s_axil_bvalid}), 64'(3'b110));

        // W arrives 5 cycles ahead of AW
        base_aw = aw_hs_cnt; base_w = w_hs_cnt;
        s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
        @(negedge clk);
        s_axil_wvalid = 1'b0;
        chk("t2_w_held_ready", 64'({s_axil_wready, s_axil_awready}), 64'(2'b01));
        repeat (5) @(negedge clk);
        chk("t2_no_axi_activity", 64'((aw_hs_cnt - base_aw) + (w_hs_cnt - base_w)), 64'(0));
        chk("t2_m_valids_low", 64'({m_axi_awvalid, m_axi_wvalid, s_axil_wready}), 64'(0));
        s_axil_awaddr = 32'h3000; s_axil_awprot = 3'b000; s_axil_awvalid = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        wait_bvalid(lat);
        chk("t2_b_latency", 64'(lat), 64'(3));
        chk("t2_one_burst", 64'({aw_hs_cnt - base_aw, w_hs_cnt - base_w}), {32'd1, 32'd1});
        chk("t2_w_beat", 64'({cap_awaddr, cap_wdata}), {32'h3000, 32'hCAFEF00D});
        chk("t2_wstrb", 64'(cap_wstrb), 64'(4'h3));
        take_b(resp);

        // Read with AR delayed 4 cycles, error response passed through
        ar_delay = 4; s_rdata = 32'h12345678; s_rresp = 2'b11;
        s_axil_araddr = 32'h2004; s_axil_arprot = 3'b001; s_axil_arvalid = 1'b1;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        chk("t3_arready_busy", 64'(s_axil_arready), 64'(0));
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stable &= (m_axi_arvalid === 1'b1) && (m_axi_araddr === 32'h2004) && (m_axi_arprot === 3'b001);
            @(negedge clk);
        end
        chk("t3_ar_stable", 64'(stable), 64'(1));
        wait_rvalid(lat);
        chk("t3_rvalid_seen", 64'(s_axil_rvalid), 64'(1));
        chk("t3_ar_fields", 64'({cap_ar_fields, cap_araddr}), {6'd0, EXP_FIELDS, 32'h2004});
        take_r(data, resp);
        chk("t3_rdata", 64'(data), 64'(32'h12345678));
        chk("t3_rresp", 64'(resp), 64'(2'b11));
        ar_delay = 0;

        // Concurrent write and read, B held off by the AXI-Lite master for 10 cycles
        s_rdata = 32'hA5A5A5A5; s_rresp = 2'b00; s_bresp = 2'b00;
        chk("t4_all_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
        s_axil_awaddr = 32'h4000; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h11112222; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        s_axil_araddr = 32'h5000; s_axil_arvalid = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        wait_rvalid(lat);
        chk("t4_r_latency", 64'(lat), 64'(3));
        take_r(data, resp);
        chk("t4_rdata", 64'({data, 30'd0, resp}), {32'hA5A5A5A5, 32'd0});
        chk("t4_arready_back", 64'({s_axil_arready, s_axil_bvalid, s_axil_awready}), 64'(3'b110));
        repeat (6) @(negedge clk);
        chk("t4_bvalid_held", 64'(s_axil_bvalid), 64'(1));
        take_b(resp);
        chk("t4_bresp", 64'({cap_wdata, 30'd0, resp}), {32'h11112222, 32'd0});

        // Mismatched BID, then RLAST low
        s_bid = 8'd1; s_bresp = 2'b01;
        send_aw_w(32'h8000, 32'h0F0F0F0F, 4'hF, 3'b000);
        wait_bvalid(lat);
        take_b(resp);
`ifdef AXIL_AXI_ADAPTER_RESP_CHECK_EN
        chk("t5_bid_check", 64'(resp), 64'(2'b10));
`else
        chk("t5_bresp_verbatim", 64'(resp), 64'(2'b01));
`endif
        s_bid = 8'd0; s_bresp = 2'b00;
        s_rlast = 1'b0; s_rresp = 2'b00; s_rdata = 32'h0BADF00D;
        s_axil_araddr = 32'h9000; s_axil_arvalid = 1'b1;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        wait_rvalid(lat);
        take_r(data, resp);
        chk("t5_rdata_pass", 64'(data), 64'(32'h0BADF00D));
`ifdef AXIL_AXI_ADAPTER_RESP_CHECK_EN
        chk("t5_rlast_check", 64'(resp), 64'(2'b10));
`else
        chk("t5_rresp_verbatim", 64'(resp), 64'(2'b00));
`endif
        s_rlast = 1'b1;

        // Reset while waiting for B
        b_hold = 1'b1;
        send_aw_w(32'h6000, 32'h55AA55AA, 4'hF, 3'b111);
        @(negedge clk);
        chk("t6_wait_b", 64'({m_axi_bready, s_axil_awready}), 64'(2'b10));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready, m_axi_bready}), 64'(4'b1110));
        chk("t6_rst_payload", {m_axi_awaddr, m_axi_wdata}, 64'(0));
        chk("t6_rst_prot_valid", 64'({m_axi_awprot, m_axi_awvalid, s_axil_bvalid}), 64'(0));
        @(negedge clk);
        rst = 1'b0; b_hold = 1'b0;
        @(negedge clk);
        send_aw_w(32'h7000, 32'h13579BDF, 4'hF, 3'b000);
        wait_bvalid(lat);
        chk("t6_after_rst_latency", 64'(lat), 64'(3));
        chk("t6_after_rst_beat", {cap_awaddr, cap_wdata}, {32'h7000, 32'h13579BDF});
        take_b(resp);
        chk("t6_after_rst_bresp", 64'(resp), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
